// File: rtl/toll_lane_ctrl_if.sv
// toll_lane_ctrl_if: lane inputs (car, hipass) and controller outputs as a single bundle.
// Revision: 1.0
`default_nettype none

interface toll_lane_ctrl_if #(
  parameter int LANES = 2,
  parameter int ID_W  = 4,
  parameter int CNT_W = 8
);
  logic [LANES-1:0]      car;
  logic [LANES*ID_W-1:0] hipass;
  logic [2*LANES-1:0]    state;
  logic [LANES-1:0]      gate_open;
  logic [LANES-1:0]      violation;
  logic [LANES*ID_W-1:0] last_id;
  logic [CNT_W-1:0]      pass_count;

  modport master (
    output car, hipass,
    input  state, gate_open, violation, last_id, pass_count
  );

  modport slave (
    input  car, hipass,
    output state, gate_open, violation, last_id, pass_count
  );
endinterface

`default_nettype wire

// File: rtl/toll_lane_ctrl.sv
// toll_lane_ctrl: per-lane hipass toll FSMs with a shared saturating pass counter.
// Optional macro TOLL_TIMEOUT_EN builds the WAIT_PASS timeout / violation logic. Revision: 1.0
`default_nettype none

module toll_lane_ctrl #(
  parameter int LANES   = 2,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  wire                    clk,
  input  wire                    rst,
  toll_lane_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_WAIT_CAR  = 2'b01,
    S_WAIT_PASS = 2'b10,
    S_GRANT     = 2'b11
  } state_t;

  localparam logic [CNT_W+3:0] c_cnt_max = {4'b0000, {CNT_W{1'b1}}};

  logic [2*LANES-1:0]    w_state;
  logic [LANES-1:0]      w_gate;
  logic [LANES-1:0]      w_viol;
  logic [LANES*ID_W-1:0] w_last_id;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    state_t          r_state;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] w_id;
`ifdef TOLL_TIMEOUT_EN
    logic [7:0]      r_timer;
    logic            r_viol;
`endif

    assign w_id = bus.hipass[i*ID_W +: ID_W];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_id    <= '0;
`ifdef TOLL_TIMEOUT_EN
        r_timer <= '0;
        r_viol  <= 1'b0;
`endif
      end else begin
`ifdef TOLL_TIMEOUT_EN
        r_viol <= 1'b0;
`endif
        case (r_state)
          S_IDLE:     r_state <= S_WAIT_CAR;
          S_WAIT_CAR: begin
            if (bus.car[i]) begin
              r_state <= S_WAIT_PASS;
`ifdef TOLL_TIMEOUT_EN
              r_timer <= '0;
`endif
            end
          end
          S_WAIT_PASS: begin
            // A card read takes priority over an expiring timer.
            if (w_id != '0) begin
              r_state <= S_GRANT;
              r_id    <= w_id;
            end
`ifdef TOLL_TIMEOUT_EN
            else if (r_timer == 8'(TIMEOUT - 1)) begin
              r_state <= S_WAIT_CAR;
              r_viol  <= 1'b1;
            end else begin
              r_timer <= r_timer + 8'd1;
            end
`endif
          end
          S_GRANT:    r_state <= S_WAIT_CAR;
          default:    r_state <= S_IDLE;
        endcase
      end
    end

    assign w_state[2*i +: 2]        = r_state;
    assign w_gate[i]                = (r_state == S_GRANT);
    assign w_last_id[i*ID_W +: ID_W] = r_id;
`ifdef TOLL_TIMEOUT_EN
    assign w_viol[i] = r_viol;
`else
    assign w_viol[i] = 1'b0;
`endif
  end

  logic [3:0]       w_ngrant;
  logic [CNT_W+3:0] w_sum;
  logic [CNT_W-1:0] r_count;

  always_comb begin
    w_ngrant = 4'd0;
    for (int k = 0; k < LANES; k++) begin
      w_ngrant = w_ngrant + 4'(w_gate[k]);
    end
  end

  assign w_sum = {4'b0000, r_count} + {{CNT_W{1'b0}}, w_ngrant};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_sum > c_cnt_max) begin
      r_count <= {CNT_W{1'b1}};
    end else begin
      r_count <= w_sum[CNT_W-1:0];
    end
  end

  assign bus.state      = w_state;
  assign bus.gate_open  = w_gate;
  assign bus.violation  = w_viol;
  assign bus.last_id    = w_last_id;
  assign bus.pass_count = r_count;

endmodule

`default_nettype wire

// File: doc/toll_lane_ctrl.md
TOLL_LANE_CTRL -- requirements
Module: toll_lane_ctrl

Interface
REQ-001 Parameter LANES, default 2: number of independent toll lanes (1..8).
REQ-002 Parameter ID_W, default 4: hipass card ID width per lane; ID value 0 means no card.
REQ-003 Parameter TIMEOUT, default 16: cycles allowed in WAIT_PASS before violation (2..255).
REQ-004 Parameter CNT_W, default 8: width of the pass counter.
REQ-005 clk  input  1  rising-edge clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 car  input  LANES  bit i=1: vehicle detected at lane i.
REQ-008 hipass  input  LANES*ID_W  lane i card ID at bits [i*ID_W +: ID_W]; nonzero = card read.
REQ-009 state  output  2*LANES  lane i FSM state at bits [2i +: 2].
REQ-010 gate_open  output  LANES  bit i=1 while lane i is in GRANT.
REQ-011 violation  output  LANES  one-cycle pulse: lane i timed out without a card.
REQ-012 last_id  output  LANES*ID_W  last accepted card ID per lane.
REQ-013 pass_count  output  CNT_W  total granted passes, all lanes.

Function
REQ-014 Each lane SHALL run an independent registered Moore FSM: IDLE=00, WAIT_CAR=01, WAIT_PASS=10, GRANT=11.
REQ-015 IDLE SHALL go to WAIT_CAR on the next clock unconditionally.
REQ-016 WAIT_CAR SHALL go to WAIT_PASS on a clock where car[i]=1 and SHALL hold otherwise.
REQ-017 On entry to WAIT_PASS the lane timer SHALL be 0; it SHALL increment by 1 per cycle spent in WAIT_PASS.
REQ-018 WAIT_PASS with nonzero lane ID SHALL go to GRANT and SHALL register that ID into last_id on the same edge.
REQ-019 WAIT_PASS with ID 0 and timer = TIMEOUT-1 SHALL go to WAIT_CAR and SHALL assert violation[i] for exactly the next cycle.
REQ-020 A nonzero ID arriving on the same cycle as timeout SHALL win: GRANT, no violation.
REQ-021 GRANT SHALL last exactly one cycle, then go to WAIT_CAR regardless of car/hipass.
REQ-022 gate_open[i] SHALL be decoded from the registered state only: 1 iff state==GRANT; no input-to-output combinational path.
REQ-023 car and hipass SHALL be ignored in any state where they cause no transition; the ID SHALL be ignored outside WAIT_PASS.
REQ-024 pass_count SHALL add the number of lanes in GRANT each cycle (multiple lanes simultaneously counted fully) and SHALL saturate at 2^CNT_W-1.
REQ-025 Each lane's state, timer, violation and last_id SHALL be unaffected by activity on any other lane.

Reset
REQ-026 With rst=1 at a rising edge: every lane state=IDLE, timer=0, gate_open=0, violation=0, last_id=0, pass_count=0.
REQ-027 Reset mid-operation (any state, including GRANT or final timeout cycle) SHALL abort without emitting gate_open or violation on the following cycle.
REQ-028 After rst deasserts, each lane SHALL reach WAIT_CAR exactly one clock later.

Configuration
REQ-029 Macro TOLL_TIMEOUT_EN: when defined, REQ-017/019/020 timeout behaviour SHALL be present.
REQ-030 When TOLL_TIMEOUT_EN is undefined, WAIT_PASS SHALL wait indefinitely for a nonzero ID, no timer logic SHALL be built, and violation SHALL be constant 0.

Verification
REQ-031 rst 2 cycles, release -> state lane0=IDLE for 1 cycle, then WAIT_CAR; all outputs 0.
REQ-032 Lane0 car=1 one cycle, hipass lane0=4'h5 three cycles later -> GRANT for 1 cycle, gate_open[0]=1 once, last_id lane0=5, pass_count=1, back to WAIT_CAR.
REQ-033 Lane1 car=1, no card, TOLL_TIMEOUT_EN defined, TIMEOUT=16 -> after 16 WAIT_PASS cycles violation[1]=1 for 1 cycle, state WAIT_CAR, pass_count unchanged; same stimulus without macro -> remains WAIT_PASS, violation=0.
REQ-034 Both lanes in WAIT_PASS, IDs 4'h3/4'hA on same cycle -> both gate_open same cycle, pass_count increases by 2; ID arriving at timer=15 -> GRANT, no violation.
REQ-035 CNT_W=2, five grants -> pass_count 1,2,3,3,3 (saturated).
REQ-036 rst asserted on the cycle lane0 enters GRANT -> gate_open[0]=0 next cycle, pass_count=0, state IDLE.
